// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the data-memory arbiter and a synchronous single-port RAM.
// Handshake: a requester raises req with we/addr/wdata and holds it until a one-cycle ack;
// read data arrives later with a one-cycle rvalid pulse; rdata stays put until the next read.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wdata;
  logic              m0_ack;
  logic              m0_rvalid;
  logic [31:0]       m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wdata;
  logic              m1_ack;
  logic              m1_rvalid;
  logic [31:0]       m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rvalid, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rvalid, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a synchronous single-port data RAM. Port 0 has priority,
// but port 1 is guaranteed a grant after STARVE_MAX consecutive port-0 wins while it waits.
module dmem_arbiter #(
  parameter  int ADDR_W     = 14,
  parameter  int STARVE_MAX = 3,
  localparam int CNT_W      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic              m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [31:0]       m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              pick_m1;

  // Command is latched straight into the memory-facing registers so the RAM sees it
  // in the cycle right after the request is sampled.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    pick_m1     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          pick_m1     = !bus.m0_req || (bus.m1_req && (starve_q == STARVE_LIM));
          owner_d     = pick_m1;
          we_d        = pick_m1 ? bus.m1_we    : bus.m0_we;
          mem_addr_d  = pick_m1 ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d = pick_m1 ? bus.m1_wdata : bus.m0_wdata;
          mem_we_d    = we_d;
          m0_ack_d    = !pick_m1;
          m1_ack_d    = pick_m1;
          if (!pick_m1 && bus.m1_req)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
          else
            starve_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = we_q ? IDLE : RDATA;
      RDATA: begin
        if (owner_q) begin
          m1_rdata_d  = bus.mem_rdata;
          m1_rvalid_d = 1'b1;
        end else begin
          m0_rdata_d  = bus.mem_rdata;
          m0_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.m0_ack      = m0_ack_q;
  assign bus.m1_ack      = m1_ack_q;
  assign bus.m0_rvalid   = m0_rvalid_q;
  assign bus.m1_rvalid   = m1_rvalid_q;
  assign bus.m0_rdata    = m0_rdata_q;
  assign bus.m1_rdata    = m1_rdata_q;
  assign dbg_state       = state_q;
  assign dbg_starve_cnt  = starve_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14, word-address width of the shared data memory.
REQ-002 Parameter STARVE_MAX, default 3, maximum consecutive port-0 grants while port 1 is waiting.
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 m0_req  in  1  port 0 (CPU) request; held high until m0_ack.
REQ-006 m0_we  in  1  port 0 write (1) / read (0).
REQ-007 m0_addr  in  ADDR_W  port 0 word address.
REQ-008 m0_wdata  in  32  port 0 write data.
REQ-009 m0_ack  out  1  one-cycle pulse: port 0 command issued to memory.
REQ-010 m0_rvalid  out  1  one-cycle pulse: m0_rdata valid.
REQ-011 m0_rdata  out  32  port 0 read data, registered, held until the next port-0 read completes.
REQ-012 m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: port 1 (program loader / DMA), same directions, widths and meaning as port 0.
REQ-013 mem_addr  out  ADDR_W  address to synchronous single-port RAM.
REQ-014 mem_wdata  out  32  write data to RAM.
REQ-015 mem_we  out  1  RAM write enable.
REQ-016 mem_rdata  in  32  RAM read data, valid one cycle after address presented.

Function
REQ-017 FSM states IDLE, ISSUE, RDATA; every output is driven from registers.
REQ-018 IDLE: no req -> stay; any req -> latch winner id, we, addr, wdata into command registers; go ISSUE.
REQ-019 Arbitration: m0 only -> m0; m1 only -> m1; both -> m0, unless starve_cnt == STARVE_MAX, then m1.
REQ-020 starve_cnt: +1 when m0 wins with m1_req high; cleared to 0 when m1 wins or m0 wins with m1_req low; saturates at STARVE_MAX.
REQ-021 ISSUE (exactly one cycle): mem_addr/mem_wdata = latched values, mem_we = latched we, ack pulse to owner only; write -> IDLE, read -> RDATA.
REQ-022 RDATA (one cycle): capture mem_rdata into owner's rdata register; owner's rvalid high in the following cycle; -> IDLE.
REQ-023 Latency from req sampled in IDLE at edge k: ack and mem_we during cycle k+1; read rvalid during cycle k+3; write returns to IDLE at k+2.
REQ-024 Requests are sampled only in IDLE; req inputs in ISSUE/RDATA are ignored; requester changes to addr/we/wdata after latching have no effect.
REQ-025 Requester drops req in the cycle after ack; req still high when the FSM next reaches IDLE is treated as a new request.
REQ-026 mem_we is 0 in every state except ISSUE with a latched write; at most one memory access per transaction.
REQ-027 mem_addr/mem_wdata hold last latched values outside ISSUE; non-owner ack/rvalid stay 0; non-owner rdata unchanged.
REQ-028 Addresses pass unmodified; no wrap or range check; address all-ones is a normal access.

Reset
REQ-029 reset = 0 forces, asynchronously: state IDLE, starve_cnt 0, command registers 0, mem_addr 0, mem_wdata 0, mem_we 0, m0/m1 ack 0, rvalid 0, rdata 0.
REQ-030 Reset asserted in ISSUE or RDATA aborts the transaction: no pending rvalid, no retained write; after release the FSM samples req in IDLE on the first rising edge.

Verification
REQ-031 m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 -> mem_we=1 one cycle with 0x010/0xDEADBEEF, m0_ack pulse; read rvalid 3 cycles after sampling, m0_rdata=0xDEADBEEF, m1 outputs stay 0.
REQ-032 m0_req and m1_req held high continuously, STARVE_MAX=3 -> grant order m0,m0,m0,m1,m0,m0,m0,m1, starve_cnt returns to 0 after each m1 grant.
REQ-033 m1 only, reads 0x3FFF then 0x0000 back-to-back -> two transactions, each ack then rvalid, correct data, no address wrap artefacts.
REQ-034 Reset pulled low in ISSUE of a write -> mem_we falls immediately, ack 0, no rvalid later; memory word at that address unchanged if reset precedes the clock edge.
REQ-035 Requester changes m0_addr 0x020->0x030 during ISSUE -> memory accessed at 0x020 only; 0x030 unaffected.
